// File: rtl/mcp3x08_spi_scan_if.sv
// Pin and request/result bundle between acquisition logic, this SPI master and the ADC.
// Pure wiring: no latency of its own.
// No backpressure: start is a pulse that is dropped while the block is busy.
interface mcp3x08_spi_scan_if #(
    parameter int RES_BITS = 10,
    parameter int NUM_CH   = 8
);
    logic                start;
    logic [2:0]          channel;
    logic                diff;
    logic                scan_en;
    logic [NUM_CH-1:0]   scan_mask;
    logic                MISO;
    logic                MOSI;
    logic                SCK;
    logic                CS;
    logic [RES_BITS-1:0] adc_data;
    logic [2:0]          adc_chan;
    logic                data_valid;
    logic                busy;

    // SPI master side (the converter controller)
    modport master (
        input  start, channel, diff, scan_en, scan_mask, MISO,
        output MOSI, SCK, CS, adc_data, adc_chan, data_valid, busy
    );

    // Requesting logic plus the ADC pins
    modport slave (
        output start, channel, diff, scan_en, scan_mask, MISO,
        input  MOSI, SCK, CS, adc_data, adc_chan, data_valid, busy
    );
endinterface

// File: rtl/mcp3x08_spi_scan.sv
// SPI master for MCP300x/MCP320x with single-shot and round-robin scan modes.
// Latency: data_valid at accept+1+CLK_DIV+2*CLK_DIV*(6+RES_BITS) cycles.
// Backpressure: none; start is ignored while busy or while scan_en is high.
module mcp3x08_spi_scan #(
    parameter int RES_BITS   = 10,
    parameter int NUM_CH     = 8,
    parameter int CLK_DIV    = 4,
    parameter int CS_HIGH_HP = 2
) (
    input  logic clk,
    input  logic rst_n,
    mcp3x08_spi_scan_if.master bus
);
    localparam int NBITS = 6 + RES_BITS;
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HOLD  = CS_HIGH_HP * CLK_DIV;
    localparam int HW    = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [2:0]    CH_MASK   = 3'(NUM_CH - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [4:0]    LAST_BIT  = 5'(NBITS);

    typedef enum logic [2:0] {
        S_IDLE, S_CS_SETUP, S_SEND_CMD, S_SAMPLE, S_READ, S_CS_HOLD
    } state_t;

    state_t              state, state_nxt;
    logic [DW-1:0]       div_cnt;
    logic [HW-1:0]       hold_cnt;
    logic                phase;      // 0: SCK low half, 1: SCK high half
    logic [4:0]          bit_cnt;    // current SCK period, 1-based
    logic [3:0]          cmd_sr;     // SGL, D2, D1, D0 still to be sent
    logic [RES_BITS-1:0] rx_sr;
    logic [2:0]          cur_chan;
    logic [2:0]          scan_ptr;
    logic                scan_en_d;
    logic                cs_q, sck_q, mosi_q, busy_q, dv_q;
    logic [RES_BITS-1:0] data_q;
    logic [2:0]          chan_q;

    logic       tick, in_frame, scan_rise, scan_hit;
    logic       accept_single, accept_scan, accept;
    logic       sck_rise, sck_fall, frame_end;
    logic [2:0] ptr_base, scan_ch, chan_sel, idx;
    logic [7:0] mask8;

    assign tick      = (div_cnt == DIV_LAST);
    assign in_frame  = (state == S_SEND_CMD) || (state == S_SAMPLE) || (state == S_READ);
    assign scan_rise = bus.scan_en & ~scan_en_d;
    // A fresh scan always restarts its search from channel 0
    assign ptr_base  = scan_rise ? 3'd0 : scan_ptr;
    // Unused upper mask bits read as zero for 4-channel parts
    assign mask8     = 8'(bus.scan_mask);

    // Round-robin search: lowest enabled channel at or above the pointer, wrapping
    always_comb begin
        scan_hit = 1'b0;
        scan_ch  = '0;
        idx      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (ptr_base + 3'(i)) & CH_MASK;
            if (!scan_hit && mask8[idx]) begin
                scan_hit = 1'b1;
                scan_ch  = idx;
            end
        end
    end

    assign accept_single = (state == S_IDLE) && bus.start && !bus.scan_en;
    assign accept_scan   = (state == S_IDLE) && bus.scan_en && scan_hit;
    assign accept        = accept_single || accept_scan;
    assign chan_sel      = accept_scan ? scan_ch : (bus.channel & CH_MASK);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state and SCK edge / end-of-frame events
    always_comb begin
        state_nxt = state;
        sck_rise  = 1'b0;
        sck_fall  = 1'b0;
        frame_end = 1'b0;
        case (state)
            S_IDLE:     if (accept) state_nxt = S_CS_SETUP;
            S_CS_SETUP: if (tick) state_nxt = S_SEND_CMD;
            S_SEND_CMD, S_SAMPLE, S_READ: begin
                if (tick) begin
                    if (!phase) begin
                        sck_rise = 1'b1;
                    end else begin
                        sck_fall = 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state_nxt = S_CS_HOLD;
                            frame_end = 1'b1;
                        end else if (bit_cnt == 5'd5) begin
                            state_nxt = S_SAMPLE;
                        end else if (bit_cnt == 5'd6) begin
                            state_nxt = S_READ;
                        end
                    end
                end
            end
            S_CS_HOLD:  if (hold_cnt == HOLD_LAST) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Timers, shift registers, registered pin outputs and results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            hold_cnt  <= '0;
            phase     <= 1'b0;
            bit_cnt   <= '0;
            cmd_sr    <= '0;
            rx_sr     <= '0;
            cur_chan  <= '0;
            scan_ptr  <= '0;
            scan_en_d <= 1'b0;
            cs_q      <= 1'b1;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            dv_q      <= 1'b0;
            data_q    <= '0;
            chan_q    <= '0;
        end else begin
            scan_en_d <= bus.scan_en;
            dv_q      <= frame_end;

            // Launch: CS low with the start bit already on MOSI
            if (accept) begin
                cs_q     <= 1'b0;
                mosi_q   <= 1'b1;
                busy_q   <= 1'b1;
                cur_chan <= chan_sel;
                cmd_sr   <= {~bus.diff, chan_sel};
            end

            if (accept_scan)    scan_ptr <= (chan_sel + 3'd1) & CH_MASK;
            else if (scan_rise) scan_ptr <= '0;

            if ((state == S_CS_SETUP) || in_frame) div_cnt <= tick ? '0 : div_cnt + 1'b1;
            else                                   div_cnt <= '0;

            if ((state == S_CS_SETUP) && tick) bit_cnt <= 5'd1;

            // Rising SCK: the ADC drives MISO on falling edges, so it is stable here
            if (sck_rise) begin
                sck_q <= 1'b1;
                phase <= 1'b1;
                if (state == S_READ) rx_sr <= {rx_sr[RES_BITS-2:0], bus.MISO};
            end

            // Falling SCK: advance to the next period and present its command bit
            if (sck_fall) begin
                sck_q   <= 1'b0;
                phase   <= 1'b0;
                bit_cnt <= bit_cnt + 5'd1;
                if (bit_cnt <= 5'd4) begin
                    mosi_q <= cmd_sr[3];
                    cmd_sr <= {cmd_sr[2:0], 1'b0};
                end else begin
                    mosi_q <= 1'b0;
                end
            end

            if (frame_end) begin
                cs_q   <= 1'b1;
                data_q <= rx_sr;
                chan_q <= cur_chan;
            end

            hold_cnt <= ((state == S_CS_HOLD) && (state_nxt == S_CS_HOLD)) ? hold_cnt + 1'b1 : '0;
            if ((state == S_CS_HOLD) && (state_nxt == S_IDLE)) busy_q <= 1'b0;
        end
    end

    assign bus.CS         = cs_q;
    assign bus.SCK        = sck_q;
    assign bus.MOSI       = mosi_q;
    assign bus.busy       = busy_q;
    assign bus.data_valid = dv_q;
    assign bus.adc_data   = data_q;
    assign bus.adc_chan   = chan_q;
endmodule

// File: tb/tb_mcp3x08_spi_scan.sv
// Directed bench: a default 10-bit instance and a 12-bit CLK_DIV=2 instance, each with an ADC model.
// The ADC models decode the command from MOSI and return a per-channel word on MISO.
// Expected values are hand-computed constants.
module tb_mcp3x08_spi_scan;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mcp3x08_spi_scan_if #(.RES_BITS(10), .NUM_CH(8)) ia ();
    mcp3x08_spi_scan_if #(.RES_BITS(12), .NUM_CH(8)) ib ();

    mcp3x08_spi_scan #(.RES_BITS(10), .NUM_CH(8), .CLK_DIV(4), .CS_HIGH_HP(2))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    mcp3x08_spi_scan #(.RES_BITS(12), .NUM_CH(8), .CLK_DIV(2), .CS_HIGH_HP(2))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    int errors = 0;
    int checks = 0;

    // ADC model for instance A (10 bits)
    logic [9:0] resp_a [8];
    int         rise_a = 0;
    logic [4:0] cmd_a  = '0;
    always @(negedge ia.CS or posedge ia.SCK) begin
        if (!ia.SCK) begin
            rise_a = 0;
        end else begin
            if (rise_a < 5) cmd_a[4-rise_a] = ia.MOSI;
            rise_a = rise_a + 1;
        end
    end
    always @(negedge ia.SCK) begin
        if (rise_a >= 6 && rise_a < 16) ia.MISO = resp_a[cmd_a[2:0]][15-rise_a];
        else                            ia.MISO = 1'b0;
    end

    // ADC model for instance B (12 bits), also timing the first SCK period
    logic [11:0] resp_b [8];
    int          rise_b = 0;
    logic [4:0]  cmd_b  = '0;
    time         t_r1_b = 0;
    time         t_r2_b = 0;
    always @(negedge ib.CS or posedge ib.SCK) begin
        if (!ib.SCK) begin
            rise_b = 0;
        end else begin
            if (rise_b < 5) cmd_b[4-rise_b] = ib.MOSI;
            rise_b = rise_b + 1;
            if (rise_b == 1) t_r1_b = $time;
            if (rise_b == 2) t_r2_b = $time;
        end
    end
    always @(negedge ib.SCK) begin
        if (rise_b >= 6 && rise_b < 18) ib.MISO = resp_b[cmd_b[2:0]][17-rise_b];
        else                            ib.MISO = 1'b0;
    end

    // Strobe counter and CS-high run length for instance A
    int dvcnt_a = 0;
    int cs_run  = 0;
    int cs_last = 0;
    always @(negedge clk) begin
        if (ia.data_valid === 1'b1) dvcnt_a = dvcnt_a + 1;
        if (ia.CS === 1'b1) begin
            cs_run = cs_run + 1;
        end else begin
            if (cs_run > 0) cs_last = cs_run;
            cs_run = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input bit sel, input logic [2:0] ch, input logic df);
        @(negedge clk);
        if (sel) begin ib.channel = ch; ib.diff = df; ib.start = 1'b1; end
        else     begin ia.channel = ch; ia.diff = df; ia.start = 1'b1; end
        @(negedge clk);
        ia.start = 1'b0;
        ib.start = 1'b0;
    endtask

    // Returns cyc such that the strobe was seen in cycle T0+cyc
    task automatic wait_dv(input bit sel, input string tag, output int cyc);
        cyc = 1;
        while ((sel ? ib.data_valid : ia.data_valid) !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_strobe"}, 32'(sel ? ib.data_valid : ia.data_valid), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int n;
        int dv0;
        int exp_ch [4];
        exp_ch = '{2, 5, 7, 2};

        rst_n = 1'b0;
        ia.start = 1'b0; ia.channel = '0; ia.diff = 1'b0; ia.scan_en = 1'b0; ia.scan_mask = '0; ia.MISO = 1'b0;
        ib.start = 1'b0; ib.channel = '0; ib.diff = 1'b0; ib.scan_en = 1'b0; ib.scan_mask = '0; ib.MISO = 1'b0;
        for (int i = 0; i < 8; i++) begin resp_a[i] = '0; resp_b[i] = '0; end
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_cs",   32'(ia.CS), 1);
        check("rst_sck",  32'(ia.SCK), 0);
        check("rst_mosi", 32'(ia.MOSI), 0);
        check("rst_data", 32'(ia.adc_data), 0);
        check("rst_chan", 32'(ia.adc_chan), 0);
        check("rst_dv",   32'(ia.data_valid), 0);
        check("rst_busy", 32'(ia.busy), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single-ended ch2
        resp_a[2] = 10'h150;
        pulse_start(0, 3'd2, 1'b0);
        check("t1_cs_low", 32'(ia.CS), 0);
        check("t1_busy",   32'(ia.busy), 1);
        wait_dv(0, "t1", cyc);
        check("t1_latency", cyc, 133);
        check("t1_data",    32'(ia.adc_data), 32'h150);
        check("t1_chan",    32'(ia.adc_chan), 2);
        check("t1_cmd",     32'(cmd_a), 32'b11010);
        check("t1_periods", rise_a, 16);
        check("t1_cs_high", 32'(ia.CS), 1);
        @(negedge clk);
        check("t1_dv_one_cycle", 32'(ia.data_valid), 0);
        check("t1_data_hold",    32'(ia.adc_data), 32'h150);
        repeat (12) @(negedge clk);

        // Differential ch7 with a start pulse in the middle of the frame
        resp_a[7] = 10'h2AA;
        resp_a[3] = 10'h033;
        dv0 = dvcnt_a;
        pulse_start(0, 3'd7, 1'b1);
        repeat (40) @(negedge clk);
        pulse_start(0, 3'd3, 1'b0);
        wait_dv(0, "t2", cyc);
        check("t2_data", 32'(ia.adc_data), 32'h2AA);
        check("t2_chan", 32'(ia.adc_chan), 7);
        check("t2_cmd",  32'(cmd_a), 32'b10111);
        repeat (30) @(negedge clk);
        check("t2_busy_after", 32'(ia.busy), 0);
        check("t2_one_strobe", dvcnt_a - dv0, 1);

        // 12-bit instance, CLK_DIV=2
        resp_b[1] = 12'hABC;
        pulse_start(1, 3'd1, 1'b0);
        wait_dv(1, "t3", cyc);
        check("t3_latency", cyc, 75);
        check("t3_data",    32'(ib.adc_data), 32'hABC);
        check("t3_chan",    32'(ib.adc_chan), 1);
        check("t3_periods", rise_b, 18);
        check("t3_sck_period_ns", 32'(t_r2_b - t_r1_b), 40);
        repeat (10) @(negedge clk);

        // Scan over channels 2, 5, 7
        for (int i = 0; i < 8; i++) resp_a[i] = 10'(10'h100 + i);
        ia.scan_mask = 8'b1010_0100;
        ia.scan_en   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_dv(0, "scan", cyc);
            check("scan_chan", 32'(ia.adc_chan), exp_ch[i]);
            check("scan_data", 32'(ia.adc_data), 32'(256 + exp_ch[i]));
            @(negedge clk);
        end
        check("scan_cs_gap_ge8", 32'(cs_last >= 8), 1);

        // Drop scan_en during the ch5 frame
        n = 0;
        while (ia.CS !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        check("scan_ch5_launch", 32'(ia.CS), 0);
        ia.scan_en = 1'b0;
        dv0 = dvcnt_a;
        wait_dv(0, "scan_stop", cyc);
        check("scan_stop_chan", 32'(ia.adc_chan), 5);
        check("scan_stop_data", 32'(ia.adc_data), 32'h105);
        repeat (30) @(negedge clk);
        check("scan_stop_busy",    32'(ia.busy), 0);
        check("scan_stop_cs",      32'(ia.CS), 1);
        check("scan_stop_strobes", dvcnt_a - dv0, 1);

        // Scan with an empty mask stays idle
        ia.scan_mask = '0;
        ia.scan_en   = 1'b1;
        repeat (10) @(negedge clk);
        check("mask0_busy", 32'(ia.busy), 0);
        check("mask0_cs",   32'(ia.CS), 1);
        ia.scan_en = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous reset during the third command bit
        pulse_start(0, 3'd4, 1'b0);
        n = 0;
        while (rise_a != 3 && n < 100) begin @(negedge clk); n++; end
        check("rst_reach_bit3", rise_a, 3);
        check("rst_mid_sck_hi", 32'(ia.SCK), 1);
        dv0 = dvcnt_a;
        #2 rst_n = 1'b0;
        #1;
        check("arst_cs",   32'(ia.CS), 1);
        check("arst_sck",  32'(ia.SCK), 0);
        check("arst_busy", 32'(ia.busy), 0);
        check("arst_mosi", 32'(ia.MOSI), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("arst_no_strobe", dvcnt_a - dv0, 0);
        check("arst_data_cleared", 32'(ia.adc_data), 0);

        // Recovery: single conversion on ch0
        resp_a[0] = 10'h3C5;
        pulse_start(0, 3'd0, 1'b0);
        wait_dv(0, "t5", cyc);
        check("t5_latency", cyc, 133);
        check("t5_data",    32'(ia.adc_data), 32'h3C5);
        check("t5_chan",    32'(ia.adc_chan), 0);
        check("t5_cmd",     32'(cmd_a), 32'b11000);
        repeat (12) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
